// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
//   Byte-addressable data memory for the load/store unit, with a one-request /
//   one-response handshake. Supports byte/half/word/double accesses, sign or
//   zero extension on loads, and range checking. After reset a clear sequencer
//   zeroes the array one word per cycle before requests are accepted.
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   req_valid     request present
//   req_ready     block accepts requests (READY state only)
//   req_write     1 = store, 0 = load
//   req_addr      byte address (ADDR_W)
//   req_size      00 byte, 01 half, 10 word, 11 double
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata     store data, low (8<<size) bits used
//   rsp_valid     one-cycle pulse, one cycle after acceptance
//   rsp_rdata     extended load data; 0 for stores and errors
//   rsp_err       access rejected (qualifies rsp_valid)
//   init_done     clear sequence finished
//
// Configuration
//   DMEM_MISALIGN_TRAP_EN  when defined, accesses with addr % N != 0 are
//                          rejected; otherwise they are done byte-wise.
// -----------------------------------------------------------------------------
module data_memory_ctrl #(
  parameter int DATA_W      = 64,
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int BPW   = DATA_W / 8;
  localparam int WORDS = DEPTH_BYTES / BPW;
  localparam int PW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int IW    = $clog2(DEPTH_BYTES);

  typedef enum logic {S_INIT, S_READY} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [7:0]      mem_q [DEPTH_BYTES];

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              accept;
  logic [3:0]        nbytes;
  logic [ADDR_W:0]   end_addr;
  logic              oob, size_bad, misal, acc_err;
  logic [63:0]       wdata64, raw, ext;

  // ---------------------------------------------------------------------------
  // Control FSM: INIT walks the clear pointer over every word, then READY.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == S_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == PW'(WORDS - 1)) begin
        state_d = S_READY;
        ptr_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign req_ready = (state_q == S_READY);
  assign init_done = (state_q == S_READY);
  assign accept    = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // Access checks
  // ---------------------------------------------------------------------------
  assign nbytes   = 4'd1 << req_size;
  // One extra bit so addresses near the top of the space cannot wrap back in.
  assign end_addr = {1'b0, req_addr} + {{(ADDR_W-3){1'b0}}, nbytes};
  assign oob      = end_addr > (ADDR_W+1)'(DEPTH_BYTES);
  assign size_bad = (DATA_W == 32) && (req_size == 2'b11);

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    misal = 1'b0;
    case (req_size)
      2'b01:   misal = req_addr[0];
      2'b10:   misal = |req_addr[1:0];
      2'b11:   misal = |req_addr[2:0];
      default: misal = 1'b0;
    endcase
  end
`else
  assign misal = 1'b0;
`endif

  assign acc_err = oob || size_bad || misal;

  // ---------------------------------------------------------------------------
  // Load path: gather up to 8 bytes little-endian, then extend. The index
  // wraps inside the array so out-of-range requests never index past the end;
  // their data is discarded anyway.
  // ---------------------------------------------------------------------------
  always_comb begin
    raw = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < nbytes)
        raw[8*k +: 8] = mem_q[req_addr[IW-1:0] + IW'(k)];
    end
  end

  always_comb begin
    ext = raw;
    case (req_size)
      2'b00: ext = req_unsigned ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      2'b01: ext = req_unsigned ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'b10: ext = req_unsigned ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: ext = raw;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered response
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_valid_d = accept;
    rsp_err_d   = accept && acc_err;
    rsp_rdata_d = '0;
    if (accept && !req_write && !acc_err)
      rsp_rdata_d = ext[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  // ---------------------------------------------------------------------------
  // Storage: no reset on the array itself; the clear sequencer zeroes it.
  // ---------------------------------------------------------------------------
  assign wdata64 = 64'(req_wdata);

  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      for (int b = 0; b < BPW; b++)
        mem_q[IW'(int'(ptr_q) * BPW + b)] <= 8'h00;
    end else if (accept && req_write && !acc_err) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < nbytes)
          mem_q[req_addr[IW-1:0] + IW'(k)] <= wdata64[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err, init_done;
  logic [63:0] rsp_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DATA_W(64), .DEPTH_BYTES(256), .ADDR_W(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_done(init_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // One request, accepted at the next rising edge; response sampled 1ns later.
  task automatic xact(input logic wr, input logic [63:0] a, input logic [1:0] sz,
                      input logic uns, input logic [63:0] wd,
                      output logic vl, output logic [63:0] rd, output logic er);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz;
    req_unsigned = uns; req_wdata = wd;
    @(posedge clk); #1;
    vl = rsp_valid; rd = rsp_rdata; er = rsp_err;
    req_valid = 1'b0;
  endtask

  task automatic acc(input string tag, input logic wr, input logic [63:0] a,
                     input logic [1:0] sz, input logic uns, input logic [63:0] wd,
                     input logic [63:0] exp_rd, input logic exp_er);
    logic vl, er;
    logic [63:0] rd;
    xact(wr, a, sz, uns, wd, vl, rd, er);
    chk({tag, ".valid"}, 64'(vl), 64'd1);
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".err"}, 64'(er), 64'(exp_er));
  endtask

  task automatic wait_init(input string tag);
    int cnt = 0;
    int seen = 0;
    while (!init_done && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      if (rsp_valid) seen++;
    end
    req_valid = 1'b0;
    chk({tag, ".cycles"}, 64'(cnt), 64'd32);
    chk({tag, ".no_rsp_in_init"}, 64'(seen), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_size = '0; req_unsigned = 1'b0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 64'(req_ready), 64'd0);
    chk("rst.init_done", 64'(init_done), 64'd0);
    chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst.rdata", rsp_rdata, 64'd0);
    chk("rst.err", 64'(rsp_err), 64'd0);

    // Release reset with a load pending: it must be ignored during INIT.
    @(negedge clk);
    reset_n = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'd0; req_size = 2'b11;
    wait_init("init1");

    // 1: ld @0 after clear
    acc("ld0", 1'b0, 64'd0, 2'b11, 1'b0, 64'd0, 64'd0, 1'b0);

    // 2: sd then ld back-to-back
    acc("sd8", 1'b1, 64'd8, 2'b11, 1'b0, 64'h0123456789ABCDEF, 64'd0, 1'b0);
    acc("ld8", 1'b0, 64'd8, 2'b11, 1'b0, 64'd0, 64'h0123456789ABCDEF, 1'b0);
    @(posedge clk); #1;
    chk("idle.rsp_valid", 64'(rsp_valid), 64'd0);

    // 3: narrow loads with extension
    acc("lb8",  1'b0, 64'd8,  2'b00, 1'b0, 64'd0, 64'hFFFFFFFFFFFFFFEF, 1'b0);
    acc("lbu8", 1'b0, 64'd8,  2'b00, 1'b1, 64'd0, 64'h00000000000000EF, 1'b0);
    acc("lh14", 1'b0, 64'd14, 2'b01, 1'b0, 64'd0, 64'h0000000000000123, 1'b0);
    acc("lw8",  1'b0, 64'd8,  2'b10, 1'b0, 64'd0, 64'hFFFFFFFF89ABCDEF, 1'b0);

    // 4: range boundaries
    acc("ld252", 1'b0, 64'd252, 2'b11, 1'b0, 64'd0, 64'd0, 1'b1);
    acc("sd248", 1'b1, 64'd248, 2'b11, 1'b0, 64'h1122334455667788, 64'd0, 1'b0);
    acc("sw254", 1'b1, 64'd254, 2'b10, 1'b0, 64'hDEADBEEFCAFEF00D, 64'd0, 1'b1);
    acc("lhu254", 1'b0, 64'd254, 2'b01, 1'b1, 64'd0, 64'h0000000000001122, 1'b0);
    acc("lb255", 1'b0, 64'd255, 2'b00, 1'b0, 64'd0, 64'h0000000000000011, 1'b0);
    acc("ld248", 1'b0, 64'd248, 2'b11, 1'b0, 64'd0, 64'h1122334455667788, 1'b0);
    acc("sb_top", 1'b1, 64'hFFFFFFFFFFFFFFFF, 2'b00, 1'b0, 64'hAA, 64'd0, 1'b1);
    acc("ld256", 1'b0, 64'd256, 2'b00, 1'b1, 64'd0, 64'd0, 1'b1);

    // 5: misaligned word load
`ifdef DMEM_MISALIGN_TRAP_EN
    acc("lw10", 1'b0, 64'd10, 2'b10, 1'b0, 64'd0, 64'd0, 1'b1);
`else
    acc("lw10", 1'b0, 64'd10, 2'b10, 1'b0, 64'd0, 64'h00000000456789AB, 1'b0);
`endif

    // 6: reset in the middle of back-to-back loads
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'd8; req_size = 2'b11;
    req_unsigned = 1'b0;
    @(posedge clk); #1;
    chk("b2b.rsp_valid", 64'(rsp_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst.rdata", rsp_rdata, 64'd0);
    chk("midrst.init_done", 64'(init_done), 64'd0);
    chk("midrst.ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_init("init2");
    acc("ld8_after_rst", 1'b0, 64'd8, 2'b11, 1'b0, 64'd0, 64'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
